// File: rtl/shot_clock_pkg.sv
// rtl/shot_clock_pkg.sv - shared types, default presets and width helper for the shot clock
package shot_clock_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam int DEFAULT_FULL_PRESET  = 24;
    localparam int DEFAULT_SHORT_PRESET = 14;

    // Bits needed to hold values 0 .. n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shot_clock_timer_sec_prescaler.sv
// rtl/shot_clock_timer_sec_prescaler.sv - divides the system clock into a one-cycle per-second tick
module sec_prescaler
    import shot_clock_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              PW   = cnt_width(CLK_PER_SEC);
    localparam logic [PW-1:0]   TERM = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = enable && (cnt_q == TERM);

    // clear wins over enable so a reload always restarts a full second
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shot_clock_timer.sv
// rtl/shot_clock_timer.sv - down-counting shot clock with reloads, pause, expiry latch and buzzer
module shot_clock_timer
    import shot_clock_pkg::*;
#(
    parameter int W                 = 5,
    parameter int FULL_PRESET       = DEFAULT_FULL_PRESET,
    parameter int SHORT_PRESET      = DEFAULT_SHORT_PRESET,
    parameter int CLK_PER_SEC       = 50_000_000,
    parameter int BUZZ_CYCLES       = 25_000_000,
    parameter bit SHORT_KEEP_HIGHER = 1'b0
) (
    input  logic         clock_in,
    input  logic         reset,
    input  logic         load_full,
    input  logic         load_short,
    input  logic         load_custom,
    input  logic [W-1:0] custom_value,
    input  logic         run,
    output logic [W-1:0] count,
    output logic         running,
    output logic         expired,
    output logic         buzzer
);

    localparam int            BW        = cnt_width(BUZZ_CYCLES);
    localparam logic [W-1:0]  FULL_V    = W'(FULL_PRESET);
    localparam logic [W-1:0]  SHORT_V   = W'(SHORT_PRESET);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic          expired_q, expired_d;
    logic          buzzer_q, buzzer_d;
    logic [BW-1:0] buzz_q, buzz_d;

    logic          load_any;
    logic [W-1:0]  load_val;
    logic          tick;
    logic          last_sec;

    assign load_any = load_full | load_short | load_custom;
    assign last_sec = (count_q == W'(1));

    sec_prescaler #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_sec_prescaler (
        .clock_in (clock_in),
        .reset    (reset),
        .clear    (load_any),
        .enable   (running),
        .tick     (tick)
    );

    // Short reload may be told never to raise the remaining time.
    always_comb begin
        load_val = custom_value;
        if (load_full) begin
            load_val = FULL_V;
        end else if (load_short) begin
            load_val = (SHORT_KEEP_HIGHER && (count_q > SHORT_V)) ? count_q : SHORT_V;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_any) begin
            state_d = (load_val != '0) ? S_COUNT : S_EXPIRED;
        end else if (tick && last_sec) begin
            state_d = S_EXPIRED;
        end
    end

    always_comb begin
        running = (state_q == S_COUNT) && run;
    end

    // A load beats a coincident tick; the buzz timer runs whether or not run is high.
    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        buzzer_d  = buzzer_q;
        buzz_d    = buzz_q;
        if (load_any) begin
            count_d   = load_val;
            expired_d = (load_val == '0);
            buzzer_d  = 1'b0;
            buzz_d    = '0;
        end else if (tick) begin
            if (last_sec) begin
                count_d   = '0;
                expired_d = 1'b1;
                buzzer_d  = 1'b1;
                buzz_d    = BUZZ_LOAD;
            end else begin
                count_d = count_q - 1'b1;
            end
        end else if (buzzer_q) begin
            if (buzz_q == '0) begin
                buzzer_d = 1'b0;
            end else begin
                buzz_d = buzz_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
            buzzer_q  <= 1'b0;
            buzz_q    <= '0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
            buzzer_q  <= buzzer_d;
            buzz_q    <= buzz_d;
        end
    end

    assign count   = count_q;
    assign expired = expired_q;
    assign buzzer  = buzzer_q;

endmodule

// File: tb/tb_shot_clock_timer.sv
// tb/tb_shot_clock_timer.sv - randomized and directed self-checking bench for shot_clock_timer
module tb_shot_clock_timer;

    localparam int W     = 5;
    localparam int CPS   = 4;
    localparam int BUZZ  = 3;
    localparam int FULL  = 24;
    localparam int SHORT = 14;

    typedef struct {
        int count;
        int phase;
        int expired;
        int buzz_left;
    } model_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_full = 1'b0;
    logic         load_short = 1'b0;
    logic         load_custom = 1'b0;
    logic [W-1:0] custom_value = '0;
    logic         run = 1'b0;

    logic [W-1:0] count0, count1;
    logic         running0, running1, expired0, expired1, buzzer0, buzzer1;

    model_t m0 = '{0, 0, 0, 0};
    model_t m1 = '{0, 0, 0, 0};
    bit     cmp_en = 1'b0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    shot_clock_timer #(
        .W(W), .FULL_PRESET(FULL), .SHORT_PRESET(SHORT), .CLK_PER_SEC(CPS),
        .BUZZ_CYCLES(BUZZ), .SHORT_KEEP_HIGHER(1'b0)
    ) u_dut0 (
        .clock_in(clk), .reset(reset), .load_full(load_full), .load_short(load_short),
        .load_custom(load_custom), .custom_value(custom_value), .run(run),
        .count(count0), .running(running0), .expired(expired0), .buzzer(buzzer0)
    );

    shot_clock_timer #(
        .W(W), .FULL_PRESET(FULL), .SHORT_PRESET(SHORT), .CLK_PER_SEC(CPS),
        .BUZZ_CYCLES(BUZZ), .SHORT_KEEP_HIGHER(1'b1)
    ) u_dut1 (
        .clock_in(clk), .reset(reset), .load_full(load_full), .load_short(load_short),
        .load_custom(load_custom), .custom_value(custom_value), .run(run),
        .count(count1), .running(running1), .expired(expired1), .buzzer(buzzer1)
    );

    // Seconds remaining plus cycles elapsed within the current second; buzzer is
    // simply "cycles of buzz still owed".
    function automatic model_t step(input model_t m, input bit rst, input bit lf, input bit ls,
                                    input bit lc, input int cv, input bit rn, input bit keep);
        model_t n = m;
        int v;
        if (rst) begin
            n = '{0, 0, 0, 0};
        end else if (lf || ls || lc) begin
            if (lf)      v = FULL;
            else if (ls) v = (keep && m.count > SHORT) ? m.count : SHORT;
            else         v = cv;
            n = '{v, 0, (v == 0) ? 1 : 0, 0};
        end else begin
            if (n.buzz_left > 0) n.buzz_left--;
            if (rn && n.count > 0) begin
                n.phase++;
                if (n.phase == CPS) begin
                    n.phase = 0;
                    n.count--;
                    if (n.count == 0) begin
                        n.expired   = 1;
                        n.buzz_left = BUZZ;
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        m0 <= step(m0, reset, load_full, load_short, load_custom, int'(custom_value), run, 1'b0);
        m1 <= step(m1, reset, load_full, load_short, load_custom, int'(custom_value), run, 1'b1);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("u0.count",   int'(count0),   m0.count);
            chk("u0.running", int'(running0), (run && m0.count > 0) ? 1 : 0);
            chk("u0.expired", int'(expired0), m0.expired);
            chk("u0.buzzer",  int'(buzzer0),  (m0.buzz_left > 0) ? 1 : 0);
            chk("u1.count",   int'(count1),   m1.count);
            chk("u1.running", int'(running1), (run && m1.count > 0) ? 1 : 0);
            chk("u1.expired", int'(expired1), m1.expired);
            chk("u1.buzzer",  int'(buzzer1),  (m1.buzz_left > 0) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit lf, input bit ls, input bit lc, input int cv);
        load_full    = lf;
        load_short   = ls;
        load_custom  = lc;
        custom_value = W'(cv);
        tick(1);
        load_full   = 1'b0;
        load_short  = 1'b0;
        load_custom = 1'b0;
    endtask

    initial begin
        tick(2);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("reset.count", int'(count0), 0);
        chk("reset.expired", int'(expired0), 0);
        chk("reset.buzzer", int'(buzzer0), 0);

        // full countdown to expiry and buzzer length
        run = 1'b1;
        pulse(1, 0, 0, 0);
        chk("t1.load", int'(count0), 24);
        tick(3);
        chk("t1.hold3", int'(count0), 24);
        tick(1);
        chk("t1.first_dec", int'(count0), 23);
        tick(92);
        chk("t1.zero", int'(count0), 0);
        chk("t1.expired", int'(expired0), 1);
        chk("t1.buzz_on", int'(buzzer0), 1);
        tick(2);
        chk("t1.buzz_3rd", int'(buzzer0), 1);
        tick(1);
        chk("t1.buzz_off", int'(buzzer0), 0);
        chk("t1.exp_hold", int'(expired0), 1);

        // pause and resume keeps the partial second
        pulse(1, 0, 0, 0);
        tick(10);
        chk("t2.run10", int'(count0), 22);
        run = 1'b0;
        tick(20);
        chk("t2.paused", int'(count0), 22);
        chk("t2.running", int'(running0), 0);
        run = 1'b1;
        tick(1);
        chk("t2.resume1", int'(count0), 22);
        tick(1);
        chk("t2.resume2", int'(count0), 21);

        // load priority and short-keep-higher
        pulse(1, 1, 1, 7);
        chk("t3.full_wins", int'(count0), 24);
        pulse(0, 1, 1, 7);
        chk("t3.short_wins", int'(count0), 14);
        chk("t3.keep_high", int'(count1), 24);
        tick(16);
        chk("t4.at20", int'(count1), 20);
        pulse(0, 1, 0, 0);
        chk("t4.kept20", int'(count1), 20);
        tick(3);
        chk("t4.still20", int'(count1), 20);
        tick(1);
        chk("t4.dec19", int'(count1), 19);
        tick(40);
        chk("t4.at9", int'(count1), 9);
        pulse(0, 1, 0, 0);
        chk("t4.raised14", int'(count1), 14);

        // load in the expiry cycle suppresses expiry; zero load expires silently
        tick(55);
        chk("t5.at1", int'(count0), 1);
        pulse(0, 0, 1, 5);
        chk("t5.count5", int'(count0), 5);
        chk("t5.no_exp", int'(expired0), 0);
        chk("t5.no_buzz", int'(buzzer0), 0);
        pulse(0, 0, 1, 0);
        chk("t5.zero", int'(count0), 0);
        chk("t5.exp", int'(expired0), 1);
        chk("t5.zero_buzz", int'(buzzer0), 0);

        // reset during the buzz
        pulse(0, 0, 1, 1);
        tick(4);
        chk("t6.buzz1", int'(buzzer0), 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6.count", int'(count0), 0);
        chk("t6.expired", int'(expired0), 0);
        chk("t6.buzzer", int'(buzzer0), 0);
        chk("t6.running", int'(running0), 0);
        pulse(1, 0, 0, 0);
        chk("t6.reload", int'(count0), 24);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            load_full    = ($urandom_range(0, 79) == 0);
            load_short   = ($urandom_range(0, 59) == 0);
            load_custom  = ($urandom_range(0, 49) == 0);
            custom_value = W'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) run = ~run;
            tick(1);
        end
        reset = 1'b0;
        load_full = 1'b0;
        load_short = 1'b0;
        load_custom = 1'b0;
        tick(2);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
